// File: rtl/instr_encoder_pkg.sv
`default_nettype none
// ============================================================================
// Module : instr_encoder_pkg
// Brief  : MIPS opcode/func fields and in_op request codes shared with the
//          control decoder.
// Rev    : 1.0  initial release
// ============================================================================
package instr_encoder_pkg;

   localparam logic [5:0] OP_R    = 6'b000000;
   localparam logic [5:0] OP_ORI  = 6'b001101;
   localparam logic [5:0] OP_LW   = 6'b100011;
   localparam logic [5:0] OP_SW   = 6'b101011;
   localparam logic [5:0] OP_BEQ  = 6'b000100;
   localparam logic [5:0] OP_LUI  = 6'b001111;
   localparam logic [5:0] OP_J    = 6'b000010;
   localparam logic [5:0] OP_JAL  = 6'b000011;

   localparam logic [5:0] FN_ADDU = 6'b100001;
   localparam logic [5:0] FN_SUBU = 6'b100011;
   localparam logic [5:0] FN_JR   = 6'b001000;

   localparam logic [3:0] IN_ADDU = 4'd0;
   localparam logic [3:0] IN_SUBU = 4'd1;
   localparam logic [3:0] IN_ORI  = 4'd2;
   localparam logic [3:0] IN_LW   = 4'd3;
   localparam logic [3:0] IN_SW   = 4'd4;
   localparam logic [3:0] IN_BEQ  = 4'd5;
   localparam logic [3:0] IN_LUI  = 4'd6;
   localparam logic [3:0] IN_J    = 4'd7;
   localparam logic [3:0] IN_JAL  = 4'd8;
   localparam logic [3:0] IN_JR   = 4'd9;

endpackage
`default_nettype wire

// File: rtl/instr_fifo.sv
`default_nettype none
// ============================================================================
// Module : instr_fifo
// Brief  : DEPTH x WIDTH synchronous FIFO, pointer-plus-wrap-bit full/empty.
// Rev    : 1.0  initial release
// ============================================================================
module instr_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             flush,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW:0]      r_wr;
   logic [AW:0]      r_rd;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_wr <= '0;
         r_rd <= '0;
      end else if (flush) begin
         r_wr <= '0;
         r_rd <= '0;
      end else begin
         if (push) r_wr <= r_wr + (AW+1)'(1);
         if (pop)  r_rd <= r_rd + (AW+1)'(1);
      end
   end

   // Storage carries no reset; validity is tracked entirely by the pointers.
   always_ff @(posedge clk) begin
      if (push && !flush) r_mem[r_wr[AW-1:0]] <= din;
   end

   assign dout  = r_mem[r_rd[AW-1:0]];
   assign empty = (r_wr == r_rd);
   assign full  = (r_wr[AW] != r_rd[AW]) && (r_wr[AW-1:0] == r_rd[AW-1:0]);

endmodule
`default_nettype wire

// File: rtl/instr_encoder.sv
`default_nettype none
// ============================================================================
// Module : instr_encoder
// Brief  : Encodes mnemonic requests into MIPS words, buffers them and writes
//          them to sequential IM addresses starting at BASE_ADDR.
// Rev    : 1.0  initial release
// ============================================================================
module instr_encoder
   import instr_encoder_pkg::*;
#(
   parameter int          DEPTH     = 4,
   parameter logic [31:0] BASE_ADDR = 32'h0000_3000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [3:0]  in_op,
   input  logic [4:0]  in_rs,
   input  logic [4:0]  in_rt,
   input  logic [4:0]  in_rd,
   input  logic [25:0] in_imm,
   input  logic        im_busy,
   output logic        im_we,
   output logic [31:0] im_addr,
   output logic [31:0] im_wdata,
   output logic [15:0] count,
   output logic        err
);

   logic [31:0] w_word;
   logic        w_legal;
   logic        w_push;
   logic        w_pop;
   logic        w_full;
   logic        w_empty;
   logic [31:0] w_head;
   logic [31:0] r_addr;

   always_comb begin
      w_word  = 32'h0000_0000;
      w_legal = 1'b1;
      case (in_op)
         IN_ADDU: w_word = {OP_R, in_rs, in_rt, in_rd, 5'b00000, FN_ADDU};
         IN_SUBU: w_word = {OP_R, in_rs, in_rt, in_rd, 5'b00000, FN_SUBU};
         IN_ORI:  w_word = {OP_ORI, in_rs, in_rt, in_imm[15:0]};
         IN_LW:   w_word = {OP_LW,  in_rs, in_rt, in_imm[15:0]};
         IN_SW:   w_word = {OP_SW,  in_rs, in_rt, in_imm[15:0]};
         IN_BEQ:  w_word = {OP_BEQ, in_rs, in_rt, in_imm[15:0]};
         IN_LUI:  w_word = {OP_LUI, 5'b00000, in_rt, in_imm[15:0]};
         IN_J:    w_word = {OP_J,   in_imm};
         IN_JAL:  w_word = {OP_JAL, in_imm};
         IN_JR:   w_word = {OP_R, in_rs, 15'b0, FN_JR};
         default: w_legal = 1'b0;
      endcase
   end

   // start outranks both FIFO ports: the arriving request is dropped.
   assign in_ready = !w_full;
   assign w_push   = in_valid && !w_full && !start;
   assign w_pop    = !w_empty && !im_busy && !start;

   instr_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (32)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .flush (start),
      .push  (w_push),
      .din   (w_word),
      .pop   (w_pop),
      .dout  (w_head),
      .full  (w_full),
      .empty (w_empty)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_addr   <= BASE_ADDR;
         im_we    <= 1'b0;
         im_addr  <= BASE_ADDR;
         im_wdata <= 32'h0000_0000;
         count    <= 16'h0000;
         err      <= 1'b0;
      end else begin
         if (w_push && !w_legal) err <= 1'b1;
         if (start) begin
            im_we  <= 1'b0;
            r_addr <= BASE_ADDR;
            count  <= 16'h0000;
         end else if (w_pop) begin
            im_we    <= 1'b1;
            im_wdata <= w_head;
            im_addr  <= r_addr;
            r_addr   <= r_addr + 32'd4;
            if (count != 16'hFFFF) count <= count + 16'd1;
         end else begin
            im_we <= 1'b0;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_instr_encoder.sv
`default_nettype none
// ============================================================================
// Module : tb_instr_encoder
// Brief  : Scoreboard bench for instr_encoder.
// Rev    : 1.0  initial release
// ============================================================================
module tb_instr_encoder;

   localparam logic [31:0] BASE = 32'h0000_3000;

   logic        clk;
   logic        reset;
   logic        start;
   logic        in_valid;
   logic        in_ready;
   logic [3:0]  in_op;
   logic [4:0]  in_rs;
   logic [4:0]  in_rt;
   logic [4:0]  in_rd;
   logic [25:0] in_imm;
   logic        im_busy;
   logic        im_we;
   logic [31:0] im_addr;
   logic [31:0] im_wdata;
   logic [15:0] count;
   logic        err;

   int          checks   = 0;
   int          failures = 0;
   logic [63:0] sb [$];
   logic [63:0] mon_exp;
   logic [31:0] exp_addr;
   logic [15:0] exp_count;

   instr_encoder #(
      .DEPTH     (4),
      .BASE_ADDR (BASE)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .start    (start),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_op    (in_op),
      .in_rs    (in_rs),
      .in_rt    (in_rt),
      .in_rd    (in_rd),
      .in_imm   (in_imm),
      .im_busy  (im_busy),
      .im_we    (im_we),
      .im_addr  (im_addr),
      .im_wdata (im_wdata),
      .count    (count),
      .err      (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #300000;
      $display("FAIL watchdog expired sb_left=%0d required=0", sb.size());
      $fatal(1, "watchdog");
   end

   // Write monitor: every IM write must match the oldest expected entry.
   always @(negedge clk) begin
      if (reset && im_we) begin
         checks++;
         if (sb.size() == 0) begin
            failures++;
            $display("FAIL unexpected_write addr=%h data=%h required=no write", im_addr, im_wdata);
         end else begin
            mon_exp = sb.pop_front();
            exp_count++;
            if ({im_addr, im_wdata} !== mon_exp) begin
               failures++;
               $display("FAIL im_write addr=%h data=%h required addr=%h data=%h",
                        im_addr, im_wdata, mon_exp[63:32], mon_exp[31:0]);
            end
         end
      end
   end

   function automatic logic [31:0] enc(input logic [3:0] op, input logic [4:0] rs,
                                       input logic [4:0] rt, input logic [4:0] rd,
                                       input logic [25:0] imm);
      case (op)
         4'd0:    return {6'h00, rs, rt, rd, 5'h00, 6'h21};
         4'd1:    return {6'h00, rs, rt, rd, 5'h00, 6'h23};
         4'd2:    return {6'h0d, rs, rt, imm[15:0]};
         4'd3:    return {6'h23, rs, rt, imm[15:0]};
         4'd4:    return {6'h2b, rs, rt, imm[15:0]};
         4'd5:    return {6'h04, rs, rt, imm[15:0]};
         4'd6:    return {6'h0f, 5'h00, rt, imm[15:0]};
         4'd7:    return {6'h02, imm};
         4'd8:    return {6'h03, imm};
         4'd9:    return {6'h00, rs, 15'h0000, 6'h08};
         default: return 32'h0000_0000;
      endcase
   endfunction

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic sb_clear();
      sb.delete();
      exp_addr  = BASE;
      exp_count = 16'h0000;
   endtask

   task automatic send(input logic [3:0] op, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] rd, input logic [25:0] imm, input logic [31:0] word);
      int n = 0;
      in_valid = 1'b1;
      in_op    = op;
      in_rs    = rs;
      in_rt    = rt;
      in_rd    = rd;
      in_imm   = imm;
      while (!in_ready && n < 64) begin
         tick(1);
         n++;
      end
      checks++;
      if (!in_ready) begin
         failures++;
         $display("FAIL send_timeout in_ready=%b required=1", in_ready);
         in_valid = 1'b0;
      end else begin
         @(posedge clk);
         sb.push_back({exp_addr, word});
         exp_addr = exp_addr + 32'd4;
         #1;
      end
   endtask

   task automatic idle();
      in_valid = 1'b0;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick(1);
      start = 1'b0;
      sb_clear();
   endtask

   task automatic drain();
      int n = 0;
      while (sb.size() != 0 && n < 100) begin
         tick(1);
         n++;
      end
      tick(2);
      checks++;
      if (sb.size() != 0) begin
         failures++;
         $display("FAIL drain_timeout pending=%0d required=0", sb.size());
      end
   endtask

   task automatic check_count(input string tag);
      checks++;
      if (count !== exp_count) begin
         failures++;
         $display("FAIL count_%s count=%0d required=%0d", tag, count, exp_count);
      end
   endtask

   task automatic test_reset();
      reset = 1'b0;
      #1;
      checks++;
      if ({im_we, im_wdata, count, err, in_ready} !== {1'b0, 32'h0, 16'h0, 1'b0, 1'b1}) begin
         failures++;
         $display("FAIL reset_state we=%b wdata=%h count=%h err=%b ready=%b required 0/0/0/0/1",
                  im_we, im_wdata, count, err, in_ready);
      end
      tick(2);
      reset = 1'b1;
      tick(1);
      sb_clear();
   endtask

   task automatic test_single();
      pulse_start();
      send(4'd0, 5'd1, 5'd2, 5'd3, 26'h0, 32'h0022_1821);
      idle();
      checks++;
      if (im_we !== 1'b0) begin
         failures++;
         $display("FAIL latency_early im_we=%b required=0", im_we);
      end
      tick(1);
      checks++;
      if (im_we !== 1'b1 || im_addr !== 32'h3000) begin
         failures++;
         $display("FAIL latency im_we=%b addr=%h required 1 at 3000", im_we, im_addr);
      end
      drain();
      check_count("single");
   endtask

   task automatic test_back_to_back();
      pulse_start();
      send(4'd2, 5'd0,  5'd1, 5'd9, 26'h1234,  32'h3401_1234);
      send(4'd6, 5'd7,  5'd8, 5'd9, 26'hFFFF,  32'h3C08_FFFF);
      send(4'd9, 5'd31, 5'd4, 5'd5, 26'h3ABCD, 32'h03E0_0008);
      idle();
      checks++;
      if (im_we !== 1'b1) begin
         failures++;
         $display("FAIL b2b_stream1 im_we=%b required=1", im_we);
      end
      tick(1);
      checks++;
      if (im_we !== 1'b1) begin
         failures++;
         $display("FAIL b2b_stream2 im_we=%b required=1", im_we);
      end
      drain();
      check_count("b2b");
   endtask

   task automatic test_full();
      pulse_start();
      im_busy = 1'b1;
      for (int i = 0; i < 4; i++) send(4'd5, 5'd1, 5'd2, 5'd0, 26'hFFFF, 32'h1022_FFFF);
      idle();
      checks++;
      if (in_ready !== 1'b0) begin
         failures++;
         $display("FAIL full_ready in_ready=%b required=0", in_ready);
      end
      tick(3);
      checks++;
      if (in_ready !== 1'b0 || im_we !== 1'b0) begin
         failures++;
         $display("FAIL full_hold in_ready=%b im_we=%b required 0/0", in_ready, im_we);
      end
      im_busy = 1'b0;
      send(4'd5, 5'd1, 5'd2, 5'd0, 26'hFFFF, 32'h1022_FFFF);
      idle();
      drain();
      check_count("full");
   endtask

   task automatic test_illegal();
      pulse_start();
      send(4'd12, 5'd3, 5'd4, 5'd5, 26'h3FFFFFF, 32'h0000_0000);
      idle();
      checks++;
      if (err !== 1'b1) begin
         failures++;
         $display("FAIL err_set err=%b required=1", err);
      end
      drain();
      pulse_start();
      checks++;
      if (err !== 1'b1) begin
         failures++;
         $display("FAIL err_after_start err=%b required=1", err);
      end
      test_reset();
      checks++;
      if (err !== 1'b0) begin
         failures++;
         $display("FAIL err_after_reset err=%b required=0", err);
      end
   endtask

   task automatic test_start_flush();
      pulse_start();
      im_busy = 1'b1;
      send(4'd1, 5'd4, 5'd5, 5'd6, 26'h0,    enc(4'd1, 5'd4, 5'd5, 5'd6, 26'h0));
      send(4'd4, 5'd7, 5'd8, 5'd9, 26'h00F0, enc(4'd4, 5'd7, 5'd8, 5'd9, 26'h00F0));
      send(4'd3, 5'd2, 5'd3, 5'd1, 26'h8004, enc(4'd3, 5'd2, 5'd3, 5'd1, 26'h8004));
      idle();
      pulse_start();
      im_busy = 1'b0;
      tick(5);
      checks++;
      if (im_we !== 1'b0 || count !== 16'h0) begin
         failures++;
         $display("FAIL flush im_we=%b count=%0d required 0/0", im_we, count);
      end
      send(4'd0, 5'd10, 5'd11, 5'd12, 26'h0, enc(4'd0, 5'd10, 5'd11, 5'd12, 26'h0));
      idle();
      drain();
      check_count("flush");
   endtask

   task automatic test_jal_reset_mid_drain();
      int n = 0;
      pulse_start();
      send(4'd8, 5'h1F, 5'h15, 5'h0A, 26'h0000C03, 32'h0C00_0C03);
      idle();
      drain();
      for (int i = 0; i < 3; i++)
         send(4'd7, 5'd9, 5'd9, 5'd9, 26'h0100000 + 26'(i), enc(4'd7, 5'd9, 5'd9, 5'd9, 26'h0100000 + 26'(i)));
      idle();
      while (im_we !== 1'b1 && n < 20) begin
         tick(1);
         n++;
      end
      reset = 1'b0;
      #1;
      checks++;
      if ({im_we, im_wdata, count, in_ready} !== {1'b0, 32'h0, 16'h0, 1'b1}) begin
         failures++;
         $display("FAIL reset_mid_drain we=%b wdata=%h count=%0d ready=%b required 0/0/0/1",
                  im_we, im_wdata, count, in_ready);
      end
      tick(2);
      reset = 1'b1;
      tick(1);
      sb_clear();
      send(4'd2, 5'd1, 5'd1, 5'd0, 26'h00AA, enc(4'd2, 5'd1, 5'd1, 5'd0, 26'h00AA));
      idle();
      drain();
      check_count("after_reset");
   endtask

   initial begin
      reset     = 1'b1;
      start     = 1'b0;
      in_valid  = 1'b0;
      in_op     = 4'd0;
      in_rs     = 5'd0;
      in_rt     = 5'd0;
      in_rd     = 5'd0;
      in_imm    = 26'd0;
      im_busy   = 1'b0;
      exp_addr  = BASE;
      exp_count = 16'h0000;
      #2;
      test_reset();
      test_single();
      test_back_to_back();
      test_full();
      test_illegal();
      test_start_flush();
      test_jal_reset_mid_drain();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
